dcache_ctrl: RTL



---
 rtl/dcache_pkg.sv | 8 +
 rtl/dcache_array.sv | 43 ++++
 rtl/dcache_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and sizes for the direct-mapped write-through data cache.
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RESP, STORE} state_e;
  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 8;
  localparam int LINE_W      = WORD_W * LINE_WORDS;
  localparam int OFFSET_BITS = 3;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage with one combinational read port,
// a whole-line fill port and a single-word store port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES = 8,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = 32 - 5 - IDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic                   rd_valid_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [LINE_W-1:0]      rd_line_o,
  input  logic                   lw_en_i,
  input  logic [IDX_W-1:0]       lw_idx_i,
  input  logic [TAG_W-1:0]       lw_tag_i,
  input  logic [LINE_W-1:0]      lw_line_i,
  input  logic                   ww_en_i,
  input  logic [IDX_W-1:0]       ww_idx_i,
  input  logic [OFFSET_BITS-1:0] ww_off_i,
  input  logic [WORD_W-1:0]      ww_word_i
);
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else if (lw_en_i) valid_q[lw_idx_i] <= 1'b1;
  end
  // Tags and data are only meaningful behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (lw_en_i) begin
      tag_q[lw_idx_i]  <= lw_tag_i;
      data_q[lw_idx_i] <= lw_line_i;
    end
    if (ww_en_i) data_q[ww_idx_i][ww_off_i*WORD_W +: WORD_W] <= ww_word_i;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt load statistics outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic [31:0]                  LdAddr_DM,
  input  logic [LINE_WORDS*WORD_W-1:0] LdData_cache,
  output logic [31:0]                  StrAddr_DM,
  output logic [31:0]                  WriteData_DM,
`ifdef DCACHE_STATS_EN
  output logic                         WE_DM,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
`else
  output logic                         WE_DM
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 5 - IDX_W;
  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, ld_addr_q, ld_addr_d, rdata_q, rdata_d;
  logic            hit_rsp_q, hit_rsp_d, st_hit_q, st_hit_d;
  logic            rd_valid, hit, accept, lw_en, ww_en, unused;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [WORD_W-1:0] rd_word, fill_word;
  assign unused     = ^req_addr[1:0];
  assign accept     = req_valid && req_ready;
  assign hit        = rd_valid && rd_tag == req_addr[31 -: TAG_W];
  assign rd_word    = rd_line[req_addr[4:2]*WORD_W +: WORD_W];
  assign fill_word  = LdData_cache[addr_q[4:2]*WORD_W +: WORD_W];
  assign req_ready  = state_q == IDLE;
  // Pulses are masked by reset so an abandoned store neither responds nor writes memory.
  assign resp_valid = rst_n && (hit_rsp_q || state_q == RESP || state_q == STORE);
  assign WE_DM      = rst_n && state_q == STORE;
  assign resp_rdata   = rdata_q;
  assign LdAddr_DM    = ld_addr_q;
  assign StrAddr_DM   = addr_q;
  assign WriteData_DM = wdata_q;
  dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk,
    .rst_n,
    .rd_idx_i   (req_addr[5 +: IDX_W]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .lw_en_i    (lw_en && rst_n),
    .lw_idx_i   (addr_q[5 +: IDX_W]),
    .lw_tag_i   (addr_q[31 -: TAG_W]),
    .lw_line_i  (LdData_cache),
    .ww_en_i    (ww_en && rst_n),
    .ww_idx_i   (addr_q[5 +: IDX_W]),
    .ww_off_i   (addr_q[4:2]),
    .ww_word_i  (wdata_q)
  );
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_addr_d = ld_addr_q;
    rdata_d   = rdata_q;
    st_hit_d  = st_hit_q;
    hit_rsp_d = 1'b0;
    lw_en     = 1'b0;
    ww_en     = 1'b0;
    if (accept) begin
      addr_d = {req_addr[31:2], 2'b00};
      if (req_we) begin
        state_d  = STORE;
        wdata_d  = req_wdata;
        rdata_d  = '0;
        st_hit_d = hit;
      end else if (hit) begin
        hit_rsp_d = 1'b1;
        rdata_d   = rd_word;
      end else begin
        state_d   = FILL;
        ld_addr_d = {req_addr[31:5], 5'b0};
      end
    end
    if (state_q == FILL) begin
      lw_en   = 1'b1;
      rdata_d = fill_word;
      state_d = RESP;
    end
    if (state_q == RESP) state_d = IDLE;
    if (state_q == STORE) begin
      ww_en   = st_hit_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_addr_q <= '0;
      rdata_q   <= '0;
      hit_rsp_q <= 1'b0;
      st_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_addr_q <= ld_addr_d;
      rdata_q   <= rdata_d;
      hit_rsp_q <= hit_rsp_d;
      st_hit_q  <= st_hit_d;
    end
  end
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept && !req_we && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (accept && !req_we && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
